serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 26 ++
 rtl/serial_adder_ctrl_fa_bit.sv | 26 ++
 rtl/serial_adder_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_e       : controller state encoding (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH : default operand width
//   - cnt_width()   : bit-counter width for a given operand width (min 1)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // $clog2(1) is 0, which would give a zero-width counter; clamp to 1.
    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_fa_bit.sv
// -----------------------------------------------------------------------------
// fa_bit
// Combinational 1-bit full adder used as the single datapath cell of the
// bit-serial adder.
// Ports:
//   a, b  : operand bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out
// -----------------------------------------------------------------------------
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared between the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : fa_bit

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder. Operands are accepted through a valid/ready
// handshake, pushed LSB-first through one fa_bit cell (one bit per clock) with
// the running carry held in a flop, and the result {Cout,S} is returned
// through a second valid/ready handshake. done_valid rises WIDTH clocks after
// the accept edge.
//
// Optional build macro: SERIAL_ADDER_SUB_EN
//   When defined, adds input Sub. Sub=1 at accept loads ~B and a carry-in of 1
//   (Cin ignored), producing A-B with Cout=1 meaning "no borrow".
//
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous, active-high reset
//   start_valid  : operands present on A/B/Cin (and Sub)
//   start_ready  : high only in IDLE
//   A, B         : WIDTH-bit operands, sampled on accept
//   Cin          : carry-in, sampled on accept
//   S            : registered WIDTH-bit sum, held until the next completion
//   Cout         : registered final carry-out
//   done_valid   : S/Cout valid
//   done_ready   : consumer takes the result
//   Sub          : (SERIAL_ADDER_SUB_EN only) subtract select
//   busy         : state != IDLE
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             done_valid,
    input  logic             done_ready,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_valid_q, done_valid_d;
    logic             start_ready_q, start_ready_d;
    logic             busy_q, busy_d;

    logic             s_bit, c_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             accept;

    // ---------------------------------------------------------------------
    // Datapath cell
    // ---------------------------------------------------------------------
    fa_bit u_fa_bit (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (s_bit),
        .co (c_bit)
    );

    // ---------------------------------------------------------------------
    // Operand conditioning at accept
    // ---------------------------------------------------------------------
`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: A + ~B + 1.
    always_comb begin
        b_load     = Sub ? ~B : B;
        carry_load = Sub ? 1'b1 : Cin;
    end
`else
    always_comb begin
        b_load     = B;
        carry_load = Cin;
    end
`endif

    // start_ready_q is high exactly when state_q is IDLE.
    assign accept = start_valid && start_ready_q;

    // ---------------------------------------------------------------------
    // Next-state / next-data logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        s_sh_d       = s_sh_q;
        s_d          = s_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        done_valid_d = done_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_sh_d  = A;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // Sum bits enter at the MSB; after WIDTH shifts bit 0 of the
                // sum has reached position 0. Written as shift-then-insert so
                // WIDTH=1 needs no special case.
                s_sh_d            = s_sh_q >> 1;
                s_sh_d[WIDTH-1]   = s_bit;
                carry_d = c_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    s_d          = s_sh_d;
                    cout_d       = c_bit;
                    done_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end

            DONE: begin
                // A start arriving together with done_ready is not taken here;
                // it can be accepted on the following edge from IDLE.
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d      = IDLE;
                done_valid_d = 1'b0;
            end
        endcase

        // Status outputs are registered copies of the next state.
        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            s_sh_q        <= '0;
            s_q           <= '0;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            cout_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            s_sh_q        <= s_sh_d;
            s_q           <= s_d;
            cnt_q         <= cnt_d;
            carry_q       <= carry_d;
            cout_q        <= cout_d;
            done_valid_q  <= done_valid_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign S           = s_q;
    assign Cout        = cout_q;
    assign done_valid  = done_valid_q;
    assign start_ready = start_ready_q;
    assign busy        = busy_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed bench for serial_adder_ctrl (WIDTH=8). Expected {Cout,S} values are
// pushed to a scoreboard queue when an operation is started and popped when
// done_valid is observed. Inputs change and outputs are sampled on the falling
// edge of clk.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         done_ready = 1'b0;
    logic         Cin = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] S;
    logic         Cout;
    logic         start_ready;
    logic         done_valid;
    logic         busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic         Sub = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [W:0] sb[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (A),
        .B           (B),
        .Cin         (Cin),
        .S           (S),
        .Cout        (Cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub         (Sub),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with the block idle; returns on the falling
    // edge after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        check("start_ready_before_accept", 32'(start_ready), 32'd1);
        A = a;
        B = b;
        Cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        Sub = sub;
`endif
        start_valid = 1'b1;
        if (sub) sb.push_back({1'b0, a} + {1'b0, ~b} + 9'd1);
        else     sb.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        logic [W:0] exp;
        while (!done_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(W));
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({tag, "_result"}, {23'd0, Cout, S}, {23'd0, exp});
    endtask

    task automatic release_done(input string tag);
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        check({tag, "_rel_done_valid"}, 32'(done_valid), 32'd0);
        check({tag, "_rel_start_ready"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_S", 32'(S), 32'd0);
        check("rst_Cout", 32'(Cout), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start_ready", 32'(start_ready), 32'd1);

        // ---------------- basic add ----------------
        start_op(8'h5A, 8'h33, 1'b0, 1'b0);
        check("run_busy", 32'(busy), 32'd1);
        check("run_start_ready", 32'(start_ready), 32'd0);
        wait_done("add_5a_33");
        check("done_start_ready", 32'(start_ready), 32'd0);
        release_done("add_5a_33");

        // ---------------- carry out + backpressure ----------------
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done("add_ff_01");
        for (int i = 0; i < 5; i++) begin
            start_valid = i[0];
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk);
            check("bp_done_valid", 32'(done_valid), 32'd1);
            check("bp_result", {23'd0, Cout, S}, 32'h100);
            check("bp_start_ready", 32'(start_ready), 32'd0);
        end
        // done_ready together with start_valid: start must not be taken.
        start_valid = 1'b1;
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        done_ready = 1'b0;
        check("simul_busy", 32'(busy), 32'd0);
        check("simul_start_ready", 32'(start_ready), 32'd1);
        check("simul_done_valid", 32'(done_valid), 32'd0);
        check("simul_result_held", {23'd0, Cout, S}, 32'h100);

        // ---------------- all ones with carry in, then back-to-back ----------------
        start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done("add_ff_ff_1");
        release_done("add_ff_ff_1");
        start_op(8'h80, 8'h80, 1'b0, 1'b0);
        wait_done("b2b_80_80");
        release_done("b2b_80_80");

        // ---------------- abort mid-RUN ----------------
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_S", 32'(S), 32'd0);
        check("abort_Cout", 32'(Cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done_valid", 32'(done_valid), 32'd0);
        check("abort_start_ready", 32'(start_ready), 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done_valid) seen++;
            end
            check("abort_no_done", 32'(seen), 32'd0);
        end

        // ---------------- plain add after abort ----------------
        start_op(8'h0F, 8'h01, 1'b1, 1'b0);
        wait_done("add_0f_01_1");
        release_done("add_0f_01_1");

`ifdef SERIAL_ADDER_SUB_EN
        // ---------------- subtract ----------------
        start_op(8'h10, 8'h01, 1'b0, 1'b1);
        wait_done("sub_10_01");
        release_done("sub_10_01");
        start_op(8'h01, 8'h02, 1'b1, 1'b1);
        wait_done("sub_01_02");
        release_done("sub_01_02");
        start_op(8'h5A, 8'h33, 1'b0, 1'b0);
        wait_done("nosub_5a_33");
        release_done("nosub_5a_33");
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
